// File: rtl/nco_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nco_cfg_ctrl
//  Description : Configuration controller for the simple NCO core. Decodes
//                byte-wise writes of a staged phase increment and control
//                register, and commits the staged set to the active NCO
//                configuration either immediately or aligned to the
//                accumulator wrap (with a bounded wait). Also issues
//                single-cycle accumulator clear pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_cfg_ctrl #(
   parameter int                 PHASE_W        = 24,
   parameter logic [PHASE_W-1:0] RESET_INC      = 24'h000100,
   parameter int                 COMMIT_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [7:0]         dataIn,
   input  logic [7:0]         ctrlIn,
   input  logic               accWrap,
   output logic [PHASE_W-1:0] phaseInc,
   output logic [1:0]         waveSel,
   output logic               outEn,
   output logic               phaseClr,
   output logic               busy,
   output logic               timeoutFlag
);

   // Command bus bit positions
   localparam int C_BIT_WR    = 0;
   localparam int C_BIT_ADDR  = 1;
   localparam int C_BIT_COMMIT= 3;
   localparam int C_BIT_SYNC  = 4;
   localparam int C_BIT_CLR   = 6;

   // The wait counter starts at 0 on the first PEND cycle, so the last
   // allowed PEND cycle is the one where it holds COMMIT_TIMEOUT-1.
   localparam logic [7:0] C_TO_LAST = 8'(COMMIT_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [2:0]         prev_q;          // previous {clr, commit, write} bits
   state_t             state_q,     state_d;
   logic [7:0]         cnt_q,       cnt_d;
   logic               imm_q,       imm_d;      // current commit is immediate
   logic [PHASE_W-1:0] stg_inc_q,   stg_inc_d;
   logic [1:0]         stg_wave_q,  stg_wave_d;
   logic               stg_oen_q,   stg_oen_d;
   logic [PHASE_W-1:0] phase_inc_q, phase_inc_d;
   logic [1:0]         wave_sel_q,  wave_sel_d;
   logic               out_en_q,    out_en_d;
   logic               phase_clr_q, phase_clr_d;
   logic               tout_q,      tout_d;

   logic               wr_edge;
   logic               commit_edge;
   logic               clr_edge;

   // Track the raw command bits every cycle (also in reset and with enable
   // low) so a bit held high across reset release does not look like an edge.
   always_ff @(posedge clk) begin
      prev_q <= {ctrlIn[C_BIT_CLR], ctrlIn[C_BIT_COMMIT], ctrlIn[C_BIT_WR]};
   end

   // Rising-edge detection, qualified by enable
   always_comb begin
      wr_edge     = enable & ctrlIn[C_BIT_WR]     & ~prev_q[0];
      commit_edge = enable & ctrlIn[C_BIT_COMMIT] & ~prev_q[1];
      clr_edge    = enable & ctrlIn[C_BIT_CLR]    & ~prev_q[2];
   end

   // Staging register writes; accepted in every FSM state
   always_comb begin
      stg_inc_d  = stg_inc_q;
      stg_wave_d = stg_wave_q;
      stg_oen_d  = stg_oen_q;
      if (wr_edge) begin
         case (ctrlIn[C_BIT_ADDR +: 2])
            2'd0:    stg_inc_d[7:0]   = dataIn;
            2'd1:    stg_inc_d[15:8]  = dataIn;
            2'd2:    stg_inc_d[23:16] = dataIn;
            default: begin
               stg_wave_d = dataIn[1:0];
               stg_oen_d  = dataIn[2];
            end
         endcase
      end
   end

   // Commit FSM: next state, wait counter and active-configuration updates
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      imm_d       = imm_q;
      phase_inc_d = phase_inc_q;
      wave_sel_d  = wave_sel_q;
      out_en_d    = out_en_q;
      tout_d      = tout_q;

      case (state_q)
         ST_IDLE: begin
            if (commit_edge) begin
               if (ctrlIn[C_BIT_SYNC]) begin
                  state_d = ST_PEND;
                  cnt_d   = '0;
                  imm_d   = 1'b0;
               end else begin
                  state_d = ST_APPLY;
                  imm_d   = 1'b1;
               end
            end
         end

         ST_PEND: begin
            // A wrap in the same cycle as the deadline wins over the timeout
            if (accWrap) begin
               state_d = ST_APPLY;
               tout_d  = 1'b0;
            end else if (cnt_q == C_TO_LAST) begin
               state_d = ST_APPLY;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_APPLY: begin
            phase_inc_d = stg_inc_q;
            wave_sel_d  = stg_wave_q;
            out_en_d    = stg_oen_q;
            if (imm_q) begin
               tout_d = 1'b0;
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Phase clear is a one-cycle pulse following the clear edge, any state
   always_comb begin
      phase_clr_d = clr_edge;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         imm_q       <= 1'b0;
         stg_inc_q   <= '0;
         stg_wave_q  <= '0;
         stg_oen_q   <= 1'b0;
         phase_inc_q <= RESET_INC;
         wave_sel_q  <= '0;
         out_en_q    <= 1'b0;
         phase_clr_q <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         imm_q       <= imm_d;
         stg_inc_q   <= stg_inc_d;
         stg_wave_q  <= stg_wave_d;
         stg_oen_q   <= stg_oen_d;
         phase_inc_q <= phase_inc_d;
         wave_sel_q  <= wave_sel_d;
         out_en_q    <= out_en_d;
         phase_clr_q <= phase_clr_d;
         tout_q      <= tout_d;
      end
   end

   assign phaseInc    = phase_inc_q;
   assign waveSel     = wave_sel_q;
   assign outEn       = out_en_q;
   assign phaseClr    = phase_clr_q;
   assign busy        = (state_q != ST_IDLE);
   assign timeoutFlag = tout_q;

endmodule
`default_nettype wire

// File: doc/nco_cfg_ctrl.md
Name: nco_cfg_ctrl

Overview:
- Configuration controller between the tile pins and the simple NCO core.
- Decodes the 8-bit control bus into byte-wise writes of a staged 24-bit phase increment and a staged control register.
- Commits staged values to the active NCO configuration either immediately or synchronised to the NCO accumulator wrap, so the frequency changes glitch-free.
- Bounded by a timeout; also issues single-cycle phase-clear pulses to the core.

Parameters:
- PHASE_W, 24, width of the phase increment (3 bytes; fixed at 24 for byte addressing)
- RESET_INC, 24'h000100, active phase increment after reset
- COMMIT_TIMEOUT, 255, maximum cycles spent waiting for accumulator wrap (1..255)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  design enable; when low, no command is accepted
- dataIn  input  8  write data byte
- ctrlIn  input  8  command bus: [0] write strobe, [2:1] address, [3] commit, [4] sync-commit mode, [6] phase clear, [5],[7] reserved
- accWrap  input  1  one-cycle pulse from the NCO when its phase accumulator overflows
- phaseInc  output  24  active phase increment to the NCO
- waveSel  output  2  active waveform select (0 saw, 1 square, 2 triangle, 3 reserved)
- outEn  output  1  active NCO output enable
- phaseClr  output  1  one-cycle accumulator clear pulse
- busy  output  1  high while a commit is pending or being applied
- timeoutFlag  output  1  sticky: last commit was forced by timeout

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: phaseInc=RESET_INC, waveSel=0, outEn=0, phaseClr=0, busy=0, timeoutFlag=0, staging registers=0, FSM=IDLE, timeout counter=0.
- Edge-detect registers load ctrlIn during reset, so a control bit held high through reset release produces no edge.
- Edge detection: a rising edge on ctrlIn[0], [3] or [6] is recognised in cycle N when the registered previous value is 0 and the current value is 1.
  - Edge registers track ctrlIn every cycle, including while enable is low.
  - Edges occurring while enable=0 are discarded.
- Write (ctrlIn[0] edge, enable=1), updates staging at end of cycle N:
  - addr 0: stgInc[7:0] <= dataIn.
  - addr 1: stgInc[15:8] <= dataIn.
  - addr 2: stgInc[23:16] <= dataIn.
  - addr 3: stgWave <= dataIn[1:0]; stgOutEn <= dataIn[2]; dataIn[7:3] ignored.
  - Writes are accepted in every FSM state; active outputs are never changed by a write.
- Commit (ctrlIn[3] edge, enable=1, FSM=IDLE):
  - ctrlIn[4]=0: IDLE->APPLY.
  - ctrlIn[4]=1: IDLE->PEND; counter cleared.
  - Commit edges while in PEND or APPLY are ignored.
- FSM states:
  - IDLE: busy=0.
  - PEND: busy=1; counter increments each cycle. accWrap=1 -> APPLY, timeoutFlag<=0. Otherwise, when counter reaches COMMIT_TIMEOUT -> APPLY, timeoutFlag<=1. Wrap wins if both occur in the same cycle.
  - APPLY: busy=1; phaseInc<=stgInc, waveSel<=stgWave, outEn<=stgOutEn; next state IDLE. An immediate commit also clears timeoutFlag.
- Latency:
  - Immediate commit edge in cycle N -> new active values visible at cycle N+2.
  - Sync commit with wrap in cycle M -> visible at M+2.
  - A write in the same cycle as the commit edge, or any write while in PEND, is included in the applied values.
- Phase clear (ctrlIn[6] edge, enable=1): phaseClr=1 for exactly the next cycle; independent of FSM state.
- accWrap outside PEND has no effect.
- Reset mid-PEND: abandons the commit and restores all reset values.
- enable=0 while in PEND: FSM, counter and timeout continue; only new commands are blocked.
- Reserved ctrlIn bits are ignored.

Test Plan:
- Reset, then write bytes 0x56, 0x34, 0x12 to addr 0/1/2 without commit -> phaseInc stays 0x000100. Immediate commit (ctrlIn[4]=0) -> phaseInc=0x123456 two cycles after the commit edge; busy high for exactly 1 cycle.
- Write addr 3 data 0x06, sync commit; pulse accWrap 10 cycles later -> waveSel=2 and outEn=1 exactly 2 cycles after the accWrap pulse; timeoutFlag=0.
- COMMIT_TIMEOUT=255, sync commit, no accWrap -> apply after 255 PEND cycles; timeoutFlag=1. A following immediate commit clears timeoutFlag.
- Hold ctrlIn[0] high across rst deassertion -> no write occurs. Toggle commit and write while enable=0 -> staging and outputs unchanged.
- While in PEND, rewrite addr 0 with 0xAA and issue a second commit edge -> second commit ignored; wrap applies an increment with byte 0 = 0xAA.
- ctrlIn[6] rising edge during PEND -> phaseClr=1 for one cycle, FSM stays PEND. Assert rst mid-PEND -> busy=0 and phaseInc=0x000100 on the next cycle.
